// File: rtl/jump_ctrl_unit_irq.sv
// jump_ctrl_unit_irq: fetch-stage redirect controller.
// Resolves conditional/unconditional jumps, handles CALL/RET/RETI through a
// return-address stack, and services N_IRQ prioritised maskable interrupts.
// Optional build macro: JCU_NESTED_IRQ_EN enables preemption by a strictly
// higher-priority (lower index) line while an ISR is active.
module jump_ctrl_unit_irq #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       FLAG_W    = 2,
  parameter int unsigned       N_IRQ     = 4,
  parameter int unsigned       RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] VEC_BASE  = 16'hF000,
  parameter int unsigned       VEC_SHIFT = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [5:0]                         op_dec,
  input  logic [ADDR_W-1:0]                  jmp_address_pm,
  input  logic [ADDR_W-1:0]                  current_address,
  input  logic [FLAG_W-1:0]                  flag_ex,
  input  logic [N_IRQ-1:0]                   irq_req,
  input  logic [N_IRQ-1:0]                   irq_mask,
  output logic [ADDR_W-1:0]                  jmp_loc,
  output logic                               pc_mux_sel,
  output logic [N_IRQ-1:0]                   irq_ack,
  output logic [FLAG_W-1:0]                  flag_restore,
  output logic                               flag_restore_vld,
  output logic                               in_isr,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     stack_depth,
  output logic                               stack_err
);

  localparam int unsigned DEPTH_W = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned IDX_W   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  localparam logic [5:0] OP_JMP  = 6'b011000;
  localparam logic [5:0] OP_JZ   = 6'b011110;
  localparam logic [5:0] OP_JNZ  = 6'b011111;
  localparam logic [5:0] OP_JC   = 6'b011100;
  localparam logic [5:0] OP_JNC  = 6'b011101;
  localparam logic [5:0] OP_CALL = 6'b011001;
  localparam logic [5:0] OP_RET  = 6'b010000;
  localparam logic [5:0] OP_RETI = 6'b010001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAKE = 2'd1,
    ST_ISR  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0]  jmp_loc_q, jmp_loc_d;
  logic               pc_mux_sel_q, pc_mux_sel_d;
  logic [N_IRQ-1:0]   irq_ack_q, irq_ack_d;
  logic [FLAG_W-1:0]  flag_restore_q, flag_restore_d;
  logic               flag_restore_vld_q, flag_restore_vld_d;
  logic               in_isr_q, in_isr_d;
  logic [DEPTH_W-1:0] stack_depth_q, stack_depth_d;
  logic               stack_err_q, stack_err_d;

  logic [ADDR_W-1:0]  ras_addr_q [RAS_DEPTH];
  logic [ADDR_W-1:0]  ras_addr_d [RAS_DEPTH];
  logic [FLAG_W-1:0]  ras_flag_q [RAS_DEPTH];
  logic [FLAG_W-1:0]  ras_flag_d [RAS_DEPTH];

`ifdef JCU_NESTED_IRQ_EN
  logic [IDX_W-1:0]   act_idx_q, act_idx_d;
  logic [IDX_W-1:0]   prio_q [RAS_DEPTH];
  logic [IDX_W-1:0]   prio_d [RAS_DEPTH];
  logic [DEPTH_W-1:0] prio_depth_q, prio_depth_d;
`endif

  logic [N_IRQ-1:0]   irq_pend;
  logic               irq_any;
  logic [IDX_W-1:0]   win_idx;
  logic               cond_taken;
  logic [PTR_W-1:0]   top_ptr;
  logic [ADDR_W-1:0]  top_addr;
  logic [FLAG_W-1:0]  top_flag;
  logic               take_en, exec_en;
  logic               push_en, pop_en;
  logic [ADDR_W-1:0]  push_addr;
  logic [FLAG_W-1:0]  push_flag;

  assign irq_pend = irq_req & irq_mask;
  assign irq_any  = |irq_pend;
  assign top_ptr  = PTR_W'(stack_depth_q - DEPTH_W'(1));
  assign top_addr = ras_addr_q[top_ptr];
  assign top_flag = ras_flag_q[top_ptr];

  // Lowest-index pending enabled line wins.
  always_comb begin
    win_idx = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (irq_pend[i]) win_idx = IDX_W'(i);
    end
  end

  // Branch condition from opcode and EX-stage flags (bit0 = Z, bit1 = C).
  always_comb begin
    cond_taken = 1'b0;
    case (op_dec)
      OP_JMP:  cond_taken = 1'b1;
      OP_JZ:   cond_taken = flag_ex[0];
      OP_JNZ:  cond_taken = !flag_ex[0];
      OP_JC:   cond_taken = flag_ex[1];
      OP_JNC:  cond_taken = !flag_ex[1];
      default: cond_taken = 1'b0;
    endcase
  end

  // Next-state, redirect, interrupt and stack update.
  always_comb begin
    state_d            = state_q;
    jmp_loc_d          = jmp_loc_q;
    pc_mux_sel_d       = 1'b0;
    irq_ack_d          = '0;
    flag_restore_d     = flag_restore_q;
    flag_restore_vld_d = 1'b0;
    in_isr_d           = in_isr_q;
    stack_depth_d      = stack_depth_q;
    stack_err_d        = stack_err_q;
    ras_addr_d         = ras_addr_q;
    ras_flag_d         = ras_flag_q;
    take_en            = 1'b0;
    exec_en            = 1'b0;
    push_en            = 1'b0;
    pop_en             = 1'b0;
    push_addr          = '0;
    push_flag          = '0;
`ifdef JCU_NESTED_IRQ_EN
    act_idx_d          = act_idx_q;
    prio_d             = prio_q;
    prio_depth_d       = prio_depth_q;
`endif

    case (state_q)
      ST_IDLE: begin
        take_en = irq_any;
        exec_en = !irq_any;
      end
      ST_TAKE: state_d = ST_ISR;  // instruction in the shadow of the vector jump is flushed
      ST_ISR: begin
`ifdef JCU_NESTED_IRQ_EN
        take_en = irq_any && (win_idx < act_idx_q);
`endif
        exec_en = !take_en;
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_en) begin
      state_d      = ST_TAKE;
      push_en      = 1'b1;
      push_addr    = current_address;
      push_flag    = flag_ex;
      jmp_loc_d    = VEC_BASE + (ADDR_W'(win_idx) << VEC_SHIFT);
      pc_mux_sel_d = 1'b1;
      irq_ack_d    = N_IRQ'(1) << win_idx;
      in_isr_d     = 1'b1;
`ifdef JCU_NESTED_IRQ_EN
      act_idx_d    = win_idx;
      if (state_q == ST_ISR) begin
        if (prio_depth_q == DEPTH_W'(RAS_DEPTH)) begin
          stack_err_d = 1'b1;
        end else begin
          prio_d[PTR_W'(prio_depth_q)] = act_idx_q;
          prio_depth_d = prio_depth_q + DEPTH_W'(1);
        end
      end
`endif
    end

    if (exec_en) begin
      case (op_dec)
        OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC: begin
          if (cond_taken) begin
            pc_mux_sel_d = 1'b1;
            jmp_loc_d    = jmp_address_pm;
          end
        end
        OP_CALL: begin
          push_en      = 1'b1;
          push_addr    = current_address + ADDR_W'(1);
          push_flag    = flag_ex;
          pc_mux_sel_d = 1'b1;
          jmp_loc_d    = jmp_address_pm;
        end
        OP_RET, OP_RETI: begin
          if (stack_depth_q == '0) begin
            // Underflow: no redirect, fall back to IDLE
            stack_err_d = 1'b1;
            state_d     = ST_IDLE;
            in_isr_d    = 1'b0;
`ifdef JCU_NESTED_IRQ_EN
            prio_depth_d = '0;
`endif
          end else begin
            pop_en       = 1'b1;
            pc_mux_sel_d = 1'b1;
            jmp_loc_d    = top_addr;
            if (op_dec == OP_RETI) begin
              flag_restore_d     = top_flag;
              flag_restore_vld_d = 1'b1;
`ifdef JCU_NESTED_IRQ_EN
              if ((state_q == ST_ISR) && (prio_depth_q != '0)) begin
                act_idx_d    = prio_q[PTR_W'(prio_depth_q - DEPTH_W'(1))];
                prio_depth_d = prio_depth_q - DEPTH_W'(1);
              end else begin
                state_d  = ST_IDLE;
                in_isr_d = 1'b0;
              end
`else
              state_d  = ST_IDLE;
              in_isr_d = 1'b0;
`endif
            end
          end
        end
        default: ;
      endcase
    end

    if (push_en) begin
      if (stack_depth_q == DEPTH_W'(RAS_DEPTH)) begin
        stack_err_d = 1'b1;  // full: entry dropped, redirect still happens
      end else begin
        ras_addr_d[PTR_W'(stack_depth_q)] = push_addr;
        ras_flag_d[PTR_W'(stack_depth_q)] = push_flag;
        stack_depth_d = stack_depth_q + DEPTH_W'(1);
      end
    end else if (pop_en) begin
      stack_depth_d = stack_depth_q - DEPTH_W'(1);
    end
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q            <= ST_IDLE;
      jmp_loc_q          <= '0;
      pc_mux_sel_q       <= 1'b0;
      irq_ack_q          <= '0;
      flag_restore_q     <= '0;
      flag_restore_vld_q <= 1'b0;
      in_isr_q           <= 1'b0;
      stack_depth_q      <= '0;
      stack_err_q        <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_addr_q[i] <= '0;
        ras_flag_q[i] <= '0;
      end
`ifdef JCU_NESTED_IRQ_EN
      act_idx_q    <= '0;
      prio_depth_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) prio_q[i] <= '0;
`endif
    end else begin
      state_q            <= state_d;
      jmp_loc_q          <= jmp_loc_d;
      pc_mux_sel_q       <= pc_mux_sel_d;
      irq_ack_q          <= irq_ack_d;
      flag_restore_q     <= flag_restore_d;
      flag_restore_vld_q <= flag_restore_vld_d;
      in_isr_q           <= in_isr_d;
      stack_depth_q      <= stack_depth_d;
      stack_err_q        <= stack_err_d;
      ras_addr_q         <= ras_addr_d;
      ras_flag_q         <= ras_flag_d;
`ifdef JCU_NESTED_IRQ_EN
      act_idx_q    <= act_idx_d;
      prio_q       <= prio_d;
      prio_depth_q <= prio_depth_d;
`endif
    end
  end

  assign jmp_loc          = jmp_loc_q;
  assign pc_mux_sel       = pc_mux_sel_q;
  assign irq_ack          = irq_ack_q;
  assign flag_restore     = flag_restore_q;
  assign flag_restore_vld = flag_restore_vld_q;
  assign in_isr           = in_isr_q;
  assign stack_depth      = stack_depth_q;
  assign stack_err        = stack_err_q;

endmodule

// File: tb/tb_jump_ctrl_unit_irq.sv
// Testbench for jump_ctrl_unit_irq (default build, no nested interrupts).
// A queue-based reference model predicts the registered outputs one edge ahead.
module tb_jump_ctrl_unit_irq;

  localparam int unsigned N_IRQ     = 4;
  localparam int unsigned RAS_DEPTH = 4;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_JMP  = 6'b011000;
  localparam logic [5:0] OP_JZ   = 6'b011110;
  localparam logic [5:0] OP_JNZ  = 6'b011111;
  localparam logic [5:0] OP_JC   = 6'b011100;
  localparam logic [5:0] OP_JNC  = 6'b011101;
  localparam logic [5:0] OP_CALL = 6'b011001;
  localparam logic [5:0] OP_RET  = 6'b010000;
  localparam logic [5:0] OP_RETI = 6'b010001;

  logic        clk;
  logic        rst_n;
  logic [5:0]  op_dec;
  logic [15:0] jmp_address_pm;
  logic [15:0] current_address;
  logic [1:0]  flag_ex;
  logic [3:0]  irq_req;
  logic [3:0]  irq_mask;
  logic [15:0] jmp_loc;
  logic        pc_mux_sel;
  logic [3:0]  irq_ack;
  logic [1:0]  flag_restore;
  logic        flag_restore_vld;
  logic        in_isr;
  logic [2:0]  stack_depth;
  logic        stack_err;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] q_addr[$];
  logic [1:0]  q_flag[$];
  bit          m_isr;
  bit          m_take;
  logic        e_sel;
  logic [15:0] e_loc;
  logic [3:0]  e_ack;
  logic [1:0]  e_frest;
  logic        e_vld;
  logic        e_in_isr;
  logic [2:0]  e_depth;
  logic        e_err;

  jump_ctrl_unit_irq dut (
    .clk              (clk),
    .reset            (rst_n),
    .op_dec           (op_dec),
    .jmp_address_pm   (jmp_address_pm),
    .current_address  (current_address),
    .flag_ex          (flag_ex),
    .irq_req          (irq_req),
    .irq_mask         (irq_mask),
    .jmp_loc          (jmp_loc),
    .pc_mux_sel       (pc_mux_sel),
    .irq_ack          (irq_ack),
    .flag_restore     (flag_restore),
    .flag_restore_vld (flag_restore_vld),
    .in_isr           (in_isr),
    .stack_depth      (stack_depth),
    .stack_err        (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic m_push(input logic [15:0] a, input logic [1:0] f);
    if (q_addr.size() >= RAS_DEPTH) e_err = 1'b1;
    else begin
      q_addr.push_back(a);
      q_flag.push_back(f);
    end
  endtask

  // Predict outputs after the coming edge from the current inputs.
  task automatic model_step();
    logic [3:0] pend;
    logic [1:0] f;
    int win;
    bit br;
    e_sel = 1'b0;
    e_ack = '0;
    e_vld = 1'b0;
    if (!rst_n) begin
      q_addr.delete();
      q_flag.delete();
      m_isr = 0;
      m_take = 0;
      e_err = 1'b0;
      e_loc = '0;
      e_frest = '0;
    end else begin
      pend = irq_req & irq_mask;
      if (!m_isr && !m_take && pend != 4'b0000) begin
        win = 0;
        for (int i = 3; i >= 0; i--) if (pend[i]) win = i;
        m_push(current_address, flag_ex);
        e_sel = 1'b1;
        e_loc = 16'hF000 + 16'(win) * 16'd4;
        e_ack = 4'(1 << win);
        m_take = 1;
        m_isr = 1;
      end else if (m_take) begin
        m_take = 0;
      end else begin
        br = 0;
        case (op_dec)
          OP_JMP: br = 1;
          OP_JZ:  br = (flag_ex[0] == 1'b1);
          OP_JNZ: br = (flag_ex[0] == 1'b0);
          OP_JC:  br = (flag_ex[1] == 1'b1);
          OP_JNC: br = (flag_ex[1] == 1'b0);
          OP_CALL: begin
            m_push(current_address + 16'd1, flag_ex);
            br = 1;
          end
          OP_RET, OP_RETI: begin
            if (q_addr.size() == 0) begin
              e_err = 1'b1;
              m_isr = 0;
            end else begin
              e_sel = 1'b1;
              e_loc = q_addr.pop_back();
              f = q_flag.pop_back();
              if (op_dec == OP_RETI) begin
                e_frest = f;
                e_vld = 1'b1;
                m_isr = 0;
              end
            end
          end
          default: br = 0;
        endcase
        if (br) begin
          e_sel = 1'b1;
          e_loc = jmp_address_pm;
        end
      end
    end
    e_in_isr = m_isr;
    e_depth = 3'(q_addr.size());
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    op_dec = OP_NOP;
    irq_req = '0;
    irq_mask = 4'hF;
    flag_ex = '0;
    jmp_address_pm = '0;
    current_address = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (pc_mux_sel !== 1'b0) begin errors++; $display("FAIL rst_sel got %0b want 0", pc_mux_sel); end
    checks++; if (jmp_loc !== 16'h0) begin errors++; $display("FAIL rst_loc got %h want 0000", jmp_loc); end
    checks++; if (irq_ack !== 4'h0) begin errors++; $display("FAIL rst_ack got %b want 0000", irq_ack); end
    checks++; if (flag_restore !== 2'b00 || flag_restore_vld !== 1'b0) begin errors++; $display("FAIL rst_frest got %b/%b want 00/0", flag_restore, flag_restore_vld); end
    checks++; if (in_isr !== 1'b0 || stack_depth !== 3'd0 || stack_err !== 1'b0) begin errors++; $display("FAIL rst_state got isr=%0b depth=%0d err=%0b want 0/0/0", in_isr, stack_depth, stack_err); end
  endtask

  task automatic test_cond_jumps();
    logic [5:0] ops [5];
    ops = '{OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC};
    op_dec = OP_JZ; flag_ex = 2'b01; jmp_address_pm = 16'h0007; current_address = 16'h0030;
    tick();
    checks++; if (pc_mux_sel !== 1'b1 || jmp_loc !== 16'h0007) begin errors++; $display("FAIL jz_taken got sel=%0b loc=%h want 1/0007", pc_mux_sel, jmp_loc); end
    op_dec = OP_NOP;
    tick();
    checks++; if (pc_mux_sel !== 1'b0) begin errors++; $display("FAIL jz_pulse got sel=%0b want 0", pc_mux_sel); end
    op_dec = OP_JZ; flag_ex = 2'b00;
    tick();
    checks++; if (pc_mux_sel !== 1'b0) begin errors++; $display("FAIL jz_not_taken got sel=%0b want 0", pc_mux_sel); end
    for (int n = 0; n < 30; n++) begin
      op_dec = ops[$urandom_range(0, 4)];
      flag_ex = 2'($urandom);
      jmp_address_pm = 16'($urandom);
      current_address = 16'($urandom);
      tick();
      checks++; if (pc_mux_sel !== e_sel) begin errors++; $display("FAIL cond_sel op=%b f=%b got %0b want %0b", op_dec, flag_ex, pc_mux_sel, e_sel); end
      if (e_sel) begin
        checks++; if (jmp_loc !== e_loc) begin errors++; $display("FAIL cond_loc got %h want %h", jmp_loc, e_loc); end
      end
    end
    op_dec = OP_NOP;
    tick();
  endtask

  task automatic test_call_ret();
    op_dec = OP_CALL; current_address = 16'h0010; jmp_address_pm = 16'h0100; flag_ex = 2'b00;
    tick();
    checks++; if (pc_mux_sel !== 1'b1 || jmp_loc !== 16'h0100 || stack_depth !== 3'd1) begin errors++; $display("FAIL call got sel=%0b loc=%h depth=%0d want 1/0100/1", pc_mux_sel, jmp_loc, stack_depth); end
    op_dec = OP_NOP;
    tick();
    op_dec = OP_RET;
    tick();
    checks++; if (pc_mux_sel !== 1'b1 || jmp_loc !== 16'h0011 || stack_depth !== 3'd0) begin errors++; $display("FAIL ret got sel=%0b loc=%h depth=%0d want 1/0011/0", pc_mux_sel, jmp_loc, stack_depth); end
    op_dec = OP_CALL; current_address = 16'hFFFF; jmp_address_pm = 16'h0200;
    tick();
    op_dec = OP_RET;
    tick();
    checks++; if (jmp_loc !== e_loc || jmp_loc !== 16'h0000) begin errors++; $display("FAIL call_wrap got loc=%h want 0000", jmp_loc); end
    op_dec = OP_NOP;
    tick();
  endtask

  task automatic test_irq();
    current_address = 16'h0020; flag_ex = 2'b10; irq_req = 4'b1010; irq_mask = 4'b1111; op_dec = OP_NOP;
    tick();
    checks++; if (irq_ack !== 4'b0010 || jmp_loc !== 16'hF004 || pc_mux_sel !== 1'b1) begin errors++; $display("FAIL irq1_take got ack=%b loc=%h sel=%0b want 0010/f004/1", irq_ack, jmp_loc, pc_mux_sel); end
    checks++; if (in_isr !== 1'b1) begin errors++; $display("FAIL irq1_in_isr got %0b want 1", in_isr); end
    irq_req = 4'b1000; flag_ex = 2'b01;
    tick();
    tick();
    checks++; if (irq_ack !== 4'b0000 || in_isr !== 1'b1 || pc_mux_sel !== e_sel) begin errors++; $display("FAIL irq_blocked got ack=%b isr=%0b want 0000/1", irq_ack, in_isr); end
    op_dec = OP_RETI;
    tick();
    checks++; if (jmp_loc !== 16'h0020 || pc_mux_sel !== 1'b1) begin errors++; $display("FAIL reti_loc got %h sel=%0b want 0020/1", jmp_loc, pc_mux_sel); end
    checks++; if (flag_restore !== 2'b10 || flag_restore_vld !== 1'b1 || in_isr !== 1'b0) begin errors++; $display("FAIL reti_flags got %b vld=%0b isr=%0b want 10/1/0", flag_restore, flag_restore_vld, in_isr); end
    op_dec = OP_NOP;
    tick();
    checks++; if (irq_ack !== 4'b1000 || jmp_loc !== 16'hF00C || flag_restore_vld !== 1'b0) begin errors++; $display("FAIL irq3_take got ack=%b loc=%h vld=%0b want 1000/f00c/0", irq_ack, jmp_loc, flag_restore_vld); end
    irq_req = '0;
    tick();
    op_dec = OP_RETI;
    tick();
    checks++; if (in_isr !== e_in_isr || stack_depth !== e_depth) begin errors++; $display("FAIL irq3_exit got isr=%0b depth=%0d want %0b/%0d", in_isr, stack_depth, e_in_isr, e_depth); end
    op_dec = OP_NOP;
    tick();
  endtask

  task automatic test_reset_mid_isr();
    op_dec = OP_CALL; current_address = 16'h0040; jmp_address_pm = 16'h0200;
    tick();
    op_dec = OP_NOP; irq_req = 4'b0001;
    tick();
    irq_req = '0;
    tick();
    checks++; if (in_isr !== 1'b1 || stack_depth !== 3'd2) begin errors++; $display("FAIL pre_reset got isr=%0b depth=%0d want 1/2", in_isr, stack_depth); end
    test_reset();
    irq_req = 4'b0100;
    tick();
    checks++; if (irq_ack !== 4'b0100 || stack_depth !== 3'd1) begin errors++; $display("FAIL post_reset_irq got ack=%b depth=%0d want 0100/1", irq_ack, stack_depth); end
    irq_req = '0;
    tick();
    op_dec = OP_RETI;
    tick();
    op_dec = OP_NOP;
    tick();
  endtask

  task automatic test_stack_limits();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      op_dec = OP_CALL; current_address = 16'h0100 + 16'(n); jmp_address_pm = 16'h0300 + 16'(n);
      tick();
      checks++; if (stack_depth !== e_depth || pc_mux_sel !== 1'b1) begin errors++; $display("FAIL call_fill%0d got depth=%0d sel=%0b want %0d/1", n, stack_depth, pc_mux_sel, e_depth); end
    end
    checks++; if (stack_depth !== 3'd4 || stack_err !== 1'b1 || jmp_loc !== 16'h0304) begin errors++; $display("FAIL overflow got depth=%0d err=%0b loc=%h want 4/1/0304", stack_depth, stack_err, jmp_loc); end
    op_dec = OP_NOP;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    op_dec = OP_RET;
    tick();
    checks++; if (pc_mux_sel !== 1'b0 || stack_err !== 1'b1 || stack_depth !== 3'd0 || flag_restore_vld !== 1'b0) begin errors++; $display("FAIL underflow got sel=%0b err=%0b depth=%0d want 0/1/0", pc_mux_sel, stack_err, stack_depth); end
    op_dec = OP_NOP;
    tick();
    checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b want 1", stack_err); end
  endtask

  task automatic test_collision();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    irq_req = 4'b0001; op_dec = OP_JMP; jmp_address_pm = 16'h1234; current_address = 16'h0050;
    tick();
    checks++; if (jmp_loc !== 16'hF000 || irq_ack !== 4'b0001 || pc_mux_sel !== 1'b1) begin errors++; $display("FAIL collision got loc=%h ack=%b sel=%0b want f000/0001/1", jmp_loc, irq_ack, pc_mux_sel); end
    irq_req = '0;
    tick();
    checks++; if (pc_mux_sel !== 1'b0) begin errors++; $display("FAIL flush got sel=%0b want 0", pc_mux_sel); end
    op_dec = OP_RETI;
    tick();
    checks++; if (jmp_loc !== 16'h0050 || in_isr !== 1'b0) begin errors++; $display("FAIL collision_ret got loc=%h isr=%0b want 0050/0", jmp_loc, in_isr); end
    op_dec = OP_NOP;
    tick();
  endtask

  task automatic test_random();
    logic [5:0] ops [10];
    ops = '{OP_NOP, OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC, OP_CALL, OP_RET, OP_RETI, 6'b101010};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      op_dec = ops[$urandom_range(0, 9)];
      flag_ex = 2'($urandom);
      jmp_address_pm = 16'($urandom);
      current_address = 16'($urandom);
      irq_req = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      irq_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      tick();
      checks++; if (pc_mux_sel !== e_sel) begin errors++; $display("FAIL rnd_sel cyc=%0d got %0b want %0b", n, pc_mux_sel, e_sel); end
      if (e_sel) begin
        checks++; if (jmp_loc !== e_loc) begin errors++; $display("FAIL rnd_loc cyc=%0d got %h want %h", n, jmp_loc, e_loc); end
      end
      checks++; if (irq_ack !== e_ack) begin errors++; $display("FAIL rnd_ack cyc=%0d got %b want %b", n, irq_ack, e_ack); end
      checks++; if (flag_restore_vld !== e_vld) begin errors++; $display("FAIL rnd_vld cyc=%0d got %0b want %0b", n, flag_restore_vld, e_vld); end
      if (e_vld) begin
        checks++; if (flag_restore !== e_frest) begin errors++; $display("FAIL rnd_frest cyc=%0d got %b want %b", n, flag_restore, e_frest); end
      end
      checks++; if (in_isr !== e_in_isr) begin errors++; $display("FAIL rnd_isr cyc=%0d got %0b want %0b", n, in_isr, e_in_isr); end
      checks++; if (stack_depth !== e_depth) begin errors++; $display("FAIL rnd_depth cyc=%0d got %0d want %0d", n, stack_depth, e_depth); end
      checks++; if (stack_err !== e_err) begin errors++; $display("FAIL rnd_err cyc=%0d got %0b want %0b", n, stack_err, e_err); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_cond_jumps();
    test_call_ret();
    test_irq();
    test_reset_mid_isr();
    test_stack_limits();
    test_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jump_ctrl_unit_irq.md
Name: jump_ctrl_unit_irq

Overview:
- Parametrised successor jump/branch controller for the processor fetch stage.
- Resolves conditional and unconditional jumps from the decoded opcode and EX-stage flags, and drives the PC mux select and target.
- Adds CALL/RET through a hardware return-address stack, plus N prioritised, maskable interrupt sources with vectoring and flag save/restore on RETI.

Parameters:
- ADDR_W, 16, PC/address width.
- FLAG_W, 2, flag width; bit0 = zero (Z), bit1 = carry (C).
- N_IRQ, 4, number of interrupt request lines.
- RAS_DEPTH, 4, return-address stack entries; each entry is {ADDR_W address, FLAG_W flags}.
- VEC_BASE, 16'hF000, address of the vector for irq 0.
- VEC_SHIFT, 2, vector spacing (log2 of word count).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- op_dec  in  6  decoded opcode from ID stage.
- jmp_address_pm  in  ADDR_W  jump target from program memory.
- current_address  in  ADDR_W  PC of the instruction in op_dec.
- flag_ex  in  FLAG_W  flags from EX stage.
- irq_req  in  N_IRQ  level-sensitive requests.
- irq_mask  in  N_IRQ  1 = line enabled.
- jmp_loc  out  ADDR_W  redirect target.
- pc_mux_sel  out  1  1 = PC loads jmp_loc.
- irq_ack  out  N_IRQ  one-hot pulse, 1 cycle, for the serviced line.
- flag_restore  out  FLAG_W  flags popped by RETI.
- flag_restore_vld  out  1  1-cycle pulse accompanying flag_restore.
- in_isr  out  1  high while an ISR is active.
- stack_depth  out  $clog2(RAS_DEPTH+1)  occupied entries.
- stack_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset: clk and reset as named above; reset is synchronous, active-low. When reset=0 at a clk edge, all outputs and state are cleared: jmp_loc=0, pc_mux_sel=0, irq_ack=0, flag_restore=0, flag_restore_vld=0, in_isr=0, stack_depth=0, stack_err=0, FSM=IDLE. Reset mid-ISR discards the stack.
- Latency: all outputs are registered. An op sampled at edge k drives pc_mux_sel/jmp_loc during cycle k+1 for exactly one cycle.
- Opcodes (others: no redirect):
  - JMP 011000: always taken.
  - JZ 011110: taken if Z=1.
  - JNZ 011111: taken if Z=0.
  - JC 011100: taken if C=1.
  - JNC 011101: taken if C=0.
  - CALL 011001: push {current_address+1, flag_ex}, target jmp_address_pm.
  - RET 010000: pop, target = popped address.
  - RETI 010001: pop, target = popped address, flag_restore=popped flags, flag_restore_vld=1, leave ISR.
- Address arithmetic is modulo 2^ADDR_W; current_address+1 wraps.
- FSM states IDLE, TAKE, ISR:
  - IDLE→TAKE: any (irq_req & irq_mask) != 0. Winner = lowest set index.
  - TAKE (1 cycle): push {current_address, flag_ex}; jmp_loc = VEC_BASE + (idx << VEC_SHIFT); pc_mux_sel=1; irq_ack[idx]=1. op_dec is ignored (flushed) and re-executes after RETI.
  - TAKE→ISR unconditionally. In ISR, in_isr=1 and new irqs are blocked.
  - ISR→IDLE on RETI.
- Simultaneous irq and jump op in IDLE: irq wins; the op is not executed.
- Overflow (push at stack_depth==RAS_DEPTH): push dropped, stack_err=1, redirect still occurs.
- Underflow (RET/RETI at depth 0): pc_mux_sel=0, flag_restore_vld=0, stack_err=1, FSM→IDLE.
- stack_err clears only on reset.
- RETI outside ISR behaves as RET plus flag restore.

Optional Feature:
- Macro: JCU_NESTED_IRQ_EN.
- Defined: in ISR, a pending enabled line with index strictly lower than the active one preempts via TAKE. The active priority is saved in a priority stack of RAS_DEPTH entries, and RETI restores it; in_isr falls only when the priority stack empties.
- Undefined: no preemption; irqs are held off until RETI, as in the FSM above.

Test Plan:
- Reset: reset=0 for 1 edge mid-run → all outputs 0 next cycle; stack_depth=0.
- JZ taken: op=011110, flag_ex=01, jmp_address_pm=0x0007 → next cycle pc_mux_sel=1, jmp_loc=0x0007. Then flag_ex=00 → pc_mux_sel=0.
- CALL/RET: CALL at current_address=0x0010, target 0x0100 → jmp_loc=0x0100, depth=1. RET → jmp_loc=0x0011, depth=0. CALL at 0xFFFF → pushes 0x0000.
- IRQ priority: irq_req=1010, mask=1111, current_address=0x0020 → irq_ack=0010, jmp_loc=0xF004, in_isr=1. RETI → jmp_loc=0x0020, flag_restore=saved flags, vld pulse, in_isr=0; then irq 3 serviced at 0xF00C.
- Stack limits: 5 CALLs with RAS_DEPTH=4 → depth=4, stack_err=1. From reset, RET at depth 0 → pc_mux_sel=0, stack_err=1.
- Collision: irq_req=0001 with op=JMP in the same cycle → jmp_loc=0xF000, irq_ack=0001; the JMP target is not taken.
